// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: state encoding, default width
// and the divide-class ALU operation codes.
package div_iter_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIVZ = 2'd1,
        ON   = 2'd2,
        END  = 2'd3
    } div_state_e;

    typedef enum logic [0:0] {
        ALU_DIVU = 1'b0,
        ALU_DIV  = 1'b1
    } div_op_e;

endpackage

// File: rtl/div_iter_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, try to
// subtract the divisor, keep the difference only when it did not borrow.
module div_iter_step
    import div_iter_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] part_rem,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] diff_s;

    // trial subtraction; bit WIDTH of the difference is the borrow
    always_comb begin
        shifted_s = {part_rem, next_bit};
        diff_s    = shifted_s - {1'b0, divisor};
        if (diff_s[WIDTH]) begin
            rem_next = shifted_s[WIDTH-1:0];
            q_bit    = 1'b0;
        end else begin
            rem_next = diff_s[WIDTH-1:0];
            q_bit    = 1'b1;
        end
    end

endmodule

// File: rtl/div_iter.sv
// Iterative signed/unsigned divider: one quotient bit per cycle on operand
// magnitudes, sign fix-up applied as the result is captured on entry to END.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_e         state_r;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   dvs_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic               ready_r;
    logic [2*WIDTH-1:0] result_r;

    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [WIDTH-1:0]   rem_next_s;
    logic               qbit_s;
    logic [WIDTH-1:0]   quo_next_s;
    logic [WIDTH-1:0]   q_fix_s;
    logic [WIDTH-1:0]   r_fix_s;

    div_iter_step #(.WIDTH(WIDTH)) u_step (
        .part_rem (rem_r),
        .next_bit (quo_r[WIDTH-1]),
        .divisor  (dvs_r),
        .rem_next (rem_next_s),
        .q_bit    (qbit_s)
    );

    // operand magnitudes; the most negative value maps onto 2^(WIDTH-1) unsigned
    always_comb begin
        a_neg_s = signed_div_i & a[WIDTH-1];
        b_neg_s = signed_div_i & b[WIDTH-1];
        if (a_neg_s) begin
            a_mag_s = WIDTH'(0) - a;
        end else begin
            a_mag_s = a;
        end
        if (b_neg_s) begin
            b_mag_s = WIDTH'(0) - b;
        end else begin
            b_mag_s = b;
        end
    end

    // final-step quotient and truncating-division sign fix-up
    always_comb begin
        quo_next_s = {quo_r[WIDTH-2:0], qbit_s};
        if (neg_q_r) begin
            q_fix_s = WIDTH'(0) - quo_next_s;
        end else begin
            q_fix_s = quo_next_s;
        end
        if (neg_r_r) begin
            r_fix_s = WIDTH'(0) - rem_next_s;
        end else begin
            r_fix_s = rem_next_s;
        end
    end

    // control FSM, iteration datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            cnt_r    <= CW'(0);
            rem_r    <= WIDTH'(0);
            quo_r    <= WIDTH'(0);
            dvs_r    <= WIDTH'(0);
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            ready_r  <= 1'b0;
            result_r <= (2*WIDTH)'(0);
        end else begin
            ready_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_i && !annul_i) begin
                        quo_r   <= a_mag_s;
                        dvs_r   <= b_mag_s;
                        rem_r   <= WIDTH'(0);
                        cnt_r   <= CW'(0);
                        neg_q_r <= a_neg_s ^ b_neg_s;
                        neg_r_r <= a_neg_s;
                        state_r <= (b == WIDTH'(0)) ? DIVZ : ON;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DIVZ: begin
                    if (annul_i) begin
                        state_r <= IDLE;
                    end else begin
                        state_r  <= END;
                        result_r <= (2*WIDTH)'(0);
                        ready_r  <= 1'b1;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        state_r <= IDLE;
                    end else begin
                        rem_r <= rem_next_s;
                        quo_r <= quo_next_s;
                        cnt_r <= cnt_r + CW'(1);
                        if (cnt_r == LAST) begin
                            state_r  <= END;
                            result_r <= {r_fix_s, q_fix_s};
                            ready_r  <= 1'b1;
                        end else begin
                            state_r <= ON;
                        end
                    end
                end
                END: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign result_o = result_r;
    assign ready_o  = ready_r;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: an arithmetic reference model predicts every
// cycle's ready_o/result_o, and literal expectations pin the model itself.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          done_cyc = -1;
    logic [63:0] pending_res = 64'd0;
    logic [63:0] held_res = 64'd0;
    logic [63:0] last_lit = 64'd0;

    always #5 clk = ~clk;

    div_iter #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .a            (a),
        .b            (b),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    function automatic logic [63:0] model(input logic sgn, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        if (y == 32'd0) return 64'd0;
        if (sgn) begin
            sx = longint'(signed'(x));
            sy = longint'(signed'(y));
        end else begin
            sx = longint'({32'd0, x});
            sy = longint'({32'd0, y});
        end
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // per-cycle comparison against the model, sampled after each rising edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (cyc == done_cyc) held_res = pending_res;
        check("ready_cycle", {63'd0, ready_o}, {63'd0, (cyc == done_cyc)});
        check("result_cycle", result_o, held_res);
    end

    task automatic run_op(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] lit, input string name, input bit scramble);
        int lat;
        lat = (y == 32'd0) ? 2 : 33;
        signed_div_i = sgn;
        a = x;
        b = y;
        start_i = 1'b1;
        done_cyc = cyc + lat;
        pending_res = model(sgn, x, y);
        check({name, "_model"}, pending_res, lit);
        @(negedge clk);
        if (scramble) begin
            a = ~x;
            b = y ^ 32'h0000_0005;
            signed_div_i = ~sgn;
            repeat (20) @(negedge clk);
        end
        start_i = 1'b0;
        a = 32'hDEAD_BEEF;
        b = 32'h0000_0003;
        while (cyc < done_cyc) @(negedge clk);
        check({name, "_ready"}, {63'd0, ready_o}, 64'd1);
        check({name, "_result"}, result_o, lit);
        last_lit = lit;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_result", result_o, 64'd0);
        check("reset_ready", {63'd0, ready_o}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        run_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, "udiv_100_7", 1'b0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "sdiv_m7_2", 1'b0);
        run_op(1'b0, 32'hFFFF_FFF9, 32'd2, {32'd1, 32'h7FFF_FFFC}, "udiv_big_2", 1'b1);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, "sdiv_min_m1", 1'b0);
        run_op(1'b0, 32'd5, 32'd0, 64'd0, "udiv_by0", 1'b0);
        run_op(1'b1, 32'd5, 32'd0, 64'd0, "sdiv_by0", 1'b0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, "udiv_max_1", 1'b0);

        // annul in cycle 10 of an ON operation
        signed_div_i = 1'b0; a = 32'd100; b = 32'd7; start_i = 1'b1;
        done_cyc = -1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        repeat (30) @(negedge clk);
        check("annul_on_hold", result_o, last_lit);
        run_op(1'b0, 32'd20, 32'd3, {32'd2, 32'd6}, "udiv_20_3", 1'b0);

        // annul while in DIVZ
        a = 32'd5; b = 32'd0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        repeat (5) @(negedge clk);
        check("annul_divz_hold", result_o, last_lit);

        // start together with annul in IDLE is ignored
        a = 32'd9; b = 32'd3; start_i = 1'b1; annul_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        repeat (40) @(negedge clk);
        check("idle_annul_hold", result_o, last_lit);

        // reset in cycle 15 of 1000/10 with start_i held high
        signed_div_i = 1'b0; a = 32'd1000; b = 32'd10; start_i = 1'b1;
        done_cyc = cyc + 33;
        pending_res = model(1'b0, 32'd1000, 32'd10);
        repeat (15) @(negedge clk);
        rst = 1'b0;
        done_cyc = -1;
        held_res = 64'd0;
        #1;
        check("midreset_result", result_o, 64'd0);
        check("midreset_ready", {63'd0, ready_o}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        done_cyc = cyc + 33;
        pending_res = model(1'b0, 32'd1000, 32'd10);
        check("fresh_model", pending_res, {32'd0, 32'd100});
        @(negedge clk);
        start_i = 1'b0;
        while (cyc < done_cyc) @(negedge clk);
        check("fresh_ready", {63'd0, ready_o}, 64'd1);
        check("fresh_result", result_o, {32'd0, 32'd100});
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 Parameter: WIDTH, 32, operand width; iteration count equals WIDTH.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-005 a  input  WIDTH  dividend; sampled with start.
REQ-006 b  input  WIDTH  divisor; sampled with start.
REQ-007 start_i  input  1  request a division; honoured only in IDLE.
REQ-008 annul_i  input  1  abort the operation in progress.
REQ-009 result_o  output  2*WIDTH  {remainder, quotient}, remainder in the upper half.
REQ-010 ready_o  output  1  one-cycle pulse; result_o is valid while it is high.

Function
REQ-011 FSM states SHALL be exactly four: IDLE, DIVZ, ON, END.
REQ-012 IDLE, start_i=1 and annul_i=0: SHALL latch a, b and signed_div_i; go to DIVZ if b==0, else to ON with the iteration counter at 0.
REQ-013 IDLE with annul_i=1 SHALL ignore start_i and stay in IDLE.
REQ-014 ON SHALL perform one restoring shift-subtract step per cycle on the operand magnitudes.
REQ-015 ON SHALL go to END after exactly WIDTH steps.
REQ-016 Signed mode: magnitudes SHALL be two's-complement absolute values; 0x80000000 SHALL be treated as unsigned 2^31.
REQ-017 Signed mode: the quotient SHALL be negated when the operand signs differ.
REQ-018 Signed mode: the remainder SHALL take the sign of the dividend (truncating division).
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0, with no error flag.
REQ-020 DIVZ SHALL last one cycle, then go to END with the result forced to 64'h0.
REQ-021 END SHALL drive ready_o=1 for exactly one cycle and return to IDLE unconditionally.
REQ-022 start_i high in END or ON SHALL NOT restart or extend the operation.
REQ-023 Latency: with start_i first high in IDLE cycle 0, ready_o SHALL be high in cycle WIDTH+1 (33); divide-by-zero gives ready_o in cycle 2.
REQ-024 annul_i=1 in ON or DIVZ SHALL return to IDLE on the next edge with no ready_o pulse.
REQ-025 An annulled operation SHALL leave result_o unchanged.
REQ-026 annul_i in END SHALL be ignored; the pulse completes.
REQ-027 a, b and signed_div_i changing after the start cycle SHALL NOT affect the result.
REQ-028 result_o SHALL be registered, updated only on entry to END, and held until the next completed operation.
REQ-029 ready_o SHALL be registered or decoded from the state register only, with no combinational path from inputs.
REQ-030 Back-to-back: start_i high in the IDLE cycle immediately after END SHALL begin a new operation with identical latency.

Reset
REQ-031 rst=0 SHALL asynchronously force: state IDLE, counter 0, ready_o 0, result_o 64'h0, all working registers 0.
REQ-032 Reset mid-operation SHALL discard the operation; no ready_o pulse SHALL follow the reset release.
REQ-033 The first start_i is accepted in the first IDLE cycle after rst returns high.

Structure
REQ-034 The state enum (IDLE/DIVZ/ON/END) and the default WIDTH constant SHALL live in the shared package with the ALU defines.
REQ-035 One sub-module, div_iter_step, SHALL be purely combinational: partial remainder and divisor in, next partial remainder and quotient bit out.
REQ-036 div_iter SHALL hold the FSM, counter, sign fix-up and output registers.
REQ-037 No multi-cycle combinational "/" or "%" operators SHALL be used.

Verification
REQ-038 Unsigned 100/7 -> result_o={32'd2,32'd14}; ready_o high only in cycle 33.
REQ-039 Signed -7/2 (0xFFFFFFF9/0x2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; same operands unsigned -> quotient 0x7FFFFFFC, remainder 1.
REQ-040 Signed 0x80000000/0xFFFFFFFF -> {0x00000000, 0x80000000}; unsigned 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}.
REQ-041 5/0, either mode -> ready_o in cycle 2, result_o=64'h0.
REQ-042 annul_i pulsed in cycle 10 -> no ready_o pulse, result_o holds its prior value; then 20/3 -> {2,6} with full 33-cycle latency.
REQ-043 rst=0 in cycle 15 of 1000/10, start_i kept high -> outputs 0 immediately; after release, no stale pulse; fresh 1000/10 -> {0,100} in cycle 33.
